// File: rtl/keccak_round_ctrl.sv
// Round sequencer for the Keccak-f[1600] core: walks a one-hot round index through
// NR permutation rounds per accepted block and hands the result off with valid/ack.
module keccak_round_ctrl #(
  parameter int NR    = 24,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [NR-1:0]    round_onehot,
  output logic [IDX_W-1:0] round_idx,
  output logic             round_en,
  output logic             first_round,
  output logic             out_valid,
  input  logic             out_ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [NR-1:0]    round_onehot_q, round_onehot_d;
  logic [IDX_W-1:0] round_idx_q, round_idx_d;
  logic             round_en_q, round_en_d;
  logic             first_round_q, first_round_d;
  logic             out_valid_q, out_valid_d;

  // State and registered outputs; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      in_ready_q     <= 1'b1;
      round_onehot_q <= {NR{1'b0}};
      round_idx_q    <= {IDX_W{1'b0}};
      round_en_q     <= 1'b0;
      first_round_q  <= 1'b0;
      out_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      round_onehot_q <= round_onehot_d;
      round_idx_q    <= round_idx_d;
      round_en_q     <= round_en_d;
      first_round_q  <= first_round_d;
      out_valid_q    <= out_valid_d;
    end
  end

  // Next-state logic; the last round is recognised by the top one-hot bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (round_onehot_q[NR-1]) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (out_ack) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the state being entered.
  always_comb begin
    in_ready_d     = 1'b0;
    round_onehot_d = {NR{1'b0}};
    round_idx_d    = {IDX_W{1'b0}};
    round_en_d     = 1'b0;
    first_round_d  = 1'b0;
    out_valid_d    = 1'b0;
    case (state_d)
      S_IDLE: begin
        in_ready_d = 1'b1;
      end
      S_RUN: begin
        round_en_d = 1'b1;
        if (state_q == S_IDLE) begin
          round_onehot_d = {{(NR-1){1'b0}}, 1'b1};
          round_idx_d    = {IDX_W{1'b0}};
          first_round_d  = 1'b1;
        end else begin
          round_onehot_d = {round_onehot_q[NR-2:0], 1'b0};
          round_idx_d    = round_idx_q + IDX_W'(1);
          first_round_d  = 1'b0;
        end
      end
      S_DONE: begin
        out_valid_d = 1'b1;
      end
      default: begin
        in_ready_d = 1'b1;
      end
    endcase
  end

  assign in_ready     = in_ready_q;
  assign round_onehot = round_onehot_q;
  assign round_idx    = round_idx_q;
  assign round_en     = round_en_q;
  assign first_round  = first_round_q;
  assign out_valid    = out_valid_q;

endmodule
